load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum cycles spent in REQ+WAIT before a fault.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be synchronous, active-high.
REQ-004 req_valid  in  1  SHALL flag a load/store from the datapath this cycle.
REQ-005 req_we  in  1  SHALL select store (1) or load (0).
REQ-006 req_funct3  in  3  SHALL carry Instr[14:12] (size/sign).
REQ-007 req_addr  in  32  SHALL carry the ALU-computed byte address.
REQ-008 req_wdata  in  32  SHALL carry the rs2 store data.
REQ-009 stall  out  1  SHALL tell the datapath to hold PC and regfile writes.
REQ-010 done  out  1  SHALL be a one-cycle completion pulse.
REQ-011 fault  out  1  SHALL be a one-cycle pulse for misaligned, illegal-size or timed-out access.
REQ-012 rdata  out  32  SHALL carry aligned, extended load data.
REQ-013 bus_valid, bus_we  out  1; bus_addr, bus_wdata  out  32; bus_be  out  4 -- memory request channel.
REQ-014 bus_ready, bus_rvalid  in  1; bus_rdata  in  32 -- memory accept and read-return.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, DONE, ERR.
REQ-016 IDLE with req_valid: latch we/funct3/addr/wdata; legal and aligned -> REQ, otherwise -> ERR; no bus activity for ERR path.
REQ-017 Illegal: funct3 011, 110, 111, or funct3 100 with req_we=1; misaligned: halfword with addr[0]=1, word with addr[1:0]!=0.
REQ-018 REQ: bus_valid=1, bus_addr={addr[31:2],2'b00}, bus_we/bus_be/bus_wdata held stable until bus_valid&bus_ready.
REQ-019 On handshake: store -> DONE; load -> WAIT.
REQ-020 WAIT: on bus_rvalid capture extracted data into rdata, -> DONE; bus_rvalid SHALL be ignored in every other state.
REQ-021 DONE: done=1, stall=0, -> IDLE; req_valid ignored this cycle.
REQ-022 ERR: fault=1, done=1, stall=0, rdata unchanged, -> IDLE.
REQ-023 stall = (IDLE & req_valid) | REQ | WAIT, combinational.
REQ-024 bus_be: SB 0001<<addr[1:0]; SH 0011<<{addr[1],1'b0}; SW 1111.
REQ-025 bus_wdata: SB byte replicated x4; SH halfword replicated x2; SW unchanged.
REQ-026 Loads: LB/LH sign-extend, LBU/LHU zero-extend the byte/halfword selected by addr[1:0]; LW passes the word.
REQ-027 Timeout counter SHALL clear on entering REQ, increment each REQ/WAIT cycle; at TIMEOUT -> ERR, bus_valid drops next cycle.
REQ-028 rdata SHALL hold its value until the next completed load.

Reset
REQ-029 reset SHALL force state IDLE, counter 0, rdata 0; stall, done, fault, bus_valid, bus_we, bus_be all 0.
REQ-030 Reset in REQ/WAIT SHALL abort the access; bus_valid low from the next cycle; a late bus_rvalid SHALL be ignored.
REQ-031 reset SHALL override req_valid in the same cycle.

Structure
REQ-032 Package lsu_pkg SHALL hold funct3 encodings, the FSM state enum and the byte-enable base patterns.
REQ-033 Combinational sub-module load_align SHALL perform load extraction (REQ-026).

Verification
REQ-034 SW addr 0x104, data 0xDEADBEEF, ready after 2 cycles -> bus_addr 0x104, be 1111, done pulse, stall high 3 cycles.
REQ-035 LB addr 0x203, rdata bus 0x80FF1234 -> rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SH addr 0x102, data 0x0000ABCD -> be 1100, wdata 0xABCDABCD.
REQ-037 LW addr 0x101 -> fault and done pulse, bus_valid never asserted.
REQ-038 LW, bus_ready held 0 -> fault after 255 cycles, bus_valid drops.
REQ-039 Reset asserted in WAIT, then bus_rvalid=1 -> state IDLE, rdata 0, no done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states,
// byte-enable base patterns and the legality/alignment check.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Access size lives in funct3[1:0] for both loads and stores
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic access_ok(input logic       we,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic legal;
    logic aligned;
    legal = !(funct3 inside {3'b011, 3'b110, 3'b111}) &&
            !((funct3 == F3_LBU) && we);
    case (funct3[1:0])
      SZ_HALF: aligned = !addr_lo[0];
      SZ_WORD: aligned = (addr_lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal && aligned;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a bus word and sign- or
// zero-extends it according to funct3.
import lsu_pkg::*;

module load_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = word[{addr_lo, 3'b000} +: 8];
    half_s = word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data = 32'(byte_s);
      F3_LH:   data = 32'(half_s);
      F3_LBU:  data = {24'd0, byte_s};
      F3_LHU:  data = {16'd0, half_s};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one outstanding access on a simple
// valid/ready request bus with a separate read-return strobe.
import lsu_pkg::*;

module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [31:0]      load_data;
  logic [3:0]       be_q;
  logic             timed_out;
  logic             active;

  load_align u_align (
    .funct3  (f3_q),
    .addr_lo (addr_q[1:0]),
    .word    (bus_rdata),
    .data    (load_data)
  );

  assign timed_out = (cnt == CNT_LAST);
  assign active    = !reset;
  assign rdata     = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      // Counter is held at zero in IDLE so every access starts from 0
      if (state == S_IDLE)
        cnt <= '0;
      else if (state == S_REQ || state == S_WAIT)
        cnt <= cnt + 1'b1;
      if (state == S_WAIT && bus_rvalid)
        rdata_q <= load_data;
    end
  end

  // Request capture: data-only registers, no reset needed
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    case (f3_q[1:0])
      SZ_BYTE: be_q = BE_BYTE << addr_q[1:0];
      SZ_HALF: be_q = BE_HALF << {addr_q[1], 1'b0};
      default: be_q = BE_WORD;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:
        if (req_valid)
          state_n = access_ok(req_we, req_funct3, req_addr[1:0]) ? S_REQ : S_ERR;
      S_REQ:
        if (bus_ready)
          state_n = we_q ? S_DONE : S_WAIT;
        else if (timed_out)
          state_n = S_ERR;
      S_WAIT:
        if (bus_rvalid)
          state_n = S_DONE;
        else if (timed_out)
          state_n = S_ERR;
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Reset masks every control output in the cycle it is asserted
    stall     = active && ((state == S_IDLE && req_valid) ||
                           state == S_REQ || state == S_WAIT);
    done      = active && (state == S_DONE || state == S_ERR);
    fault     = active && (state == S_ERR);
    bus_valid = active && (state == S_REQ);
    bus_we    = bus_valid && we_q;
    bus_be    = bus_valid ? be_q : 4'b0000;
    bus_addr  = {addr_q[31:2], 2'b00};
    case (f3_q[1:0])
      SZ_BYTE: bus_wdata = {4{wdata_q[7:0]}};
      SZ_HALF: bus_wdata = {2{wdata_q[15:0]}};
      default: bus_wdata = wdata_q;
    endcase
  end

endmodule
